// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: 16-state TAP FSM, IR capture/shift/update and
// registered instruction decode, plus the serial TDO mux.
package jtag_tap_pkg;
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_ctrl_fsm_t;

    typedef enum logic [2:0] {
        IDCODE           = 3'd0,
        ADDR_REGISTER    = 3'd1,
        DATA_WR_REGISTER = 3'd2,
        DATA_RD_REGISTER = 3'd3,
        BYPASS           = 3'd4
    } ir_decoding_t;
endpackage

// state group         | meaning
// TEST_LOGIC_RESET    | IR forced to IDCODE, test logic idle
// RUN_TEST_IDLE       | idle between scans
// *_DR                | data-register scan path (select/capture/shift/exit/pause/update)
// *_IR                | instruction scan path, same shape as the DR side
module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter int IR_WIDTH = 4
) (
    input  logic          tck,
    input  logic          trstn,
    input  logic          tms,
    input  logic          tdi,
    input  logic          tdo_dr,
    output tap_ctrl_fsm_t tap_state,
    output ir_decoding_t  ir_dec,
    output logic          tdo,
    output logic          tdo_en
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(4'h1);

    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_sr_next;
    logic [IR_WIDTH-1:0] ir_q_next;
    tap_ctrl_fsm_t       tap_next;

    function automatic tap_ctrl_fsm_t next_state(input tap_ctrl_fsm_t s, input logic m);
        tap_ctrl_fsm_t n;
        case (s)
            TEST_LOGIC_RESET: n = m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = m ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        n = m ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       n = m ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = m ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = m ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = m ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = m ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = m ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        n = m ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = m ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = m ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = m ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = m ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = m ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = m ? SELECT_DR        : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

    // Codes are compared zero-extended so wider IRs only match with clear upper bits.
    function automatic ir_decoding_t decode(input logic [IR_WIDTH-1:0] v);
        logic [31:0] w;
        ir_decoding_t d;
        w = 32'(v);
        case (w)
            32'h1:   d = IDCODE;
            32'h2:   d = ADDR_REGISTER;
            32'h3:   d = DATA_WR_REGISTER;
            32'h4:   d = DATA_RD_REGISTER;
            default: d = BYPASS;
        endcase
        return d;
    endfunction

    always_comb begin
        tap_next   = next_state(tap_state, tms);
        ir_sr_next = ir_sr;
        case (tap_state)
            CAPTURE_IR: ir_sr_next = IR_CAPTURE;
            SHIFT_IR:   ir_sr_next = {tdi, ir_sr[IR_WIDTH-1:1]};
            default:    ;
        endcase
        ir_q_next = ir_q;
        if (tap_state == UPDATE_IR)
            ir_q_next = ir_sr;
        // Loading IDCODE on entry keeps ir_dec valid on the very first TLR cycle.
        if (tap_next == TEST_LOGIC_RESET)
            ir_q_next = IR_IDCODE;
    end

    always_ff @(posedge tck) begin
        if (!trstn) begin
            tap_state <= TEST_LOGIC_RESET;
            ir_sr     <= IR_CAPTURE;
            ir_q      <= IR_IDCODE;
            ir_dec    <= IDCODE;
        end else begin
            tap_state <= tap_next;
            ir_sr     <= ir_sr_next;
            ir_q      <= ir_q_next;
            ir_dec    <= decode(ir_q_next);
        end
    end

    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        if (tap_state == SHIFT_IR) begin
            tdo    = ir_sr[0];
            tdo_en = 1'b1;
        end else if (tap_state == SHIFT_DR) begin
            tdo    = tdo_dr;
            tdo_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed scenarios plus a random
// tms/tdi/tdo_dr run compared against a table-driven TAP model.
module tb_jtag_tap_ctrl;
    import jtag_tap_pkg::*;

    localparam int IR_W = 4;

    logic          tck;
    logic          trstn;
    logic          tms;
    logic          tdi;
    logic          tdo_dr;
    tap_ctrl_fsm_t tap_state;
    ir_decoding_t  ir_dec;
    logic          tdo;
    logic          tdo_en;

    int checks = 0;
    int errors = 0;

    jtag_tap_ctrl #(.IR_WIDTH(IR_W)) dut (
        .tck(tck), .trstn(trstn), .tms(tms), .tdi(tdi), .tdo_dr(tdo_dr),
        .tap_state(tap_state), .ir_dec(ir_dec), .tdo(tdo), .tdo_en(tdo_en)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: transition table, IR kept as plain vectors.
    tap_ctrl_fsm_t tbl0 [16];
    tap_ctrl_fsm_t tbl1 [16];
    tap_ctrl_fsm_t m_state = TEST_LOGIC_RESET;
    logic [IR_W-1:0] m_sr = 4'h1;
    logic [IR_W-1:0] m_q  = 4'h1;

    task automatic set_tr(input tap_ctrl_fsm_t s, input tap_ctrl_fsm_t n0, input tap_ctrl_fsm_t n1);
        tbl0[int'(s)] = n0;
        tbl1[int'(s)] = n1;
    endtask

    task automatic build_tbl();
        set_tr(TEST_LOGIC_RESET, RUN_TEST_IDLE, TEST_LOGIC_RESET);
        set_tr(RUN_TEST_IDLE,    RUN_TEST_IDLE, SELECT_DR);
        set_tr(SELECT_DR,        CAPTURE_DR,    SELECT_IR);
        set_tr(CAPTURE_DR,       SHIFT_DR,      EXIT1_DR);
        set_tr(SHIFT_DR,         SHIFT_DR,      EXIT1_DR);
        set_tr(EXIT1_DR,         PAUSE_DR,      UPDATE_DR);
        set_tr(PAUSE_DR,         PAUSE_DR,      EXIT2_DR);
        set_tr(EXIT2_DR,         SHIFT_DR,      UPDATE_DR);
        set_tr(UPDATE_DR,        RUN_TEST_IDLE, SELECT_DR);
        set_tr(SELECT_IR,        CAPTURE_IR,    TEST_LOGIC_RESET);
        set_tr(CAPTURE_IR,       SHIFT_IR,      EXIT1_IR);
        set_tr(SHIFT_IR,         SHIFT_IR,      EXIT1_IR);
        set_tr(EXIT1_IR,         PAUSE_IR,      UPDATE_IR);
        set_tr(PAUSE_IR,         PAUSE_IR,      EXIT2_IR);
        set_tr(EXIT2_IR,         SHIFT_IR,      UPDATE_IR);
        set_tr(UPDATE_IR,        RUN_TEST_IDLE, SELECT_DR);
    endtask

    task automatic model_update(input logic t, input logic d, input logic r);
        if (!r) begin
            m_state = TEST_LOGIC_RESET;
            m_sr    = 4'h1;
            m_q     = 4'h1;
        end else begin
            if (m_state == CAPTURE_IR)     m_sr = 4'h1;
            else if (m_state == SHIFT_IR)  m_sr = {d, m_sr[IR_W-1:1]};
            if (m_state == UPDATE_IR)      m_q = m_sr;
            m_state = t ? tbl1[int'(m_state)] : tbl0[int'(m_state)];
            if (m_state == TEST_LOGIC_RESET) m_q = 4'h1;
        end
    endtask

    function automatic ir_decoding_t exp_dec();
        case (m_q)
            4'h1:    return IDCODE;
            4'h2:    return ADDR_REGISTER;
            4'h3:    return DATA_WR_REGISTER;
            4'h4:    return DATA_RD_REGISTER;
            default: return BYPASS;
        endcase
    endfunction

    function automatic logic exp_tdo();
        if (m_state == SHIFT_IR) return m_sr[0];
        if (m_state == SHIFT_DR) return tdo_dr;
        return 1'b0;
    endfunction

    function automatic logic exp_en();
        return (m_state == SHIFT_IR) || (m_state == SHIFT_DR);
    endfunction

    task automatic step(input logic t, input logic d, input logic r);
        tms = t; tdi = d; trstn = r;
        @(posedge tck);
        model_update(t, d, r);
        #1;
    endtask

    task automatic goto_rti();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    // From RUN_TEST_IDLE: full IR scan of code, ending back in RUN_TEST_IDLE.
    task automatic load_ir(input logic [3:0] code);
        step(1, 0, 1); step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        for (int i = 0; i < 4; i++) step(i == 3, code[i], 1);
        step(1, 0, 1); step(0, 0, 1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(1'($urandom), 1'($urandom), 1'b0);
        checks++;
        if (tap_state !== TEST_LOGIC_RESET) begin
            errors++; $display("FAIL reset_state got %s want TEST_LOGIC_RESET", tap_state.name());
        end
        checks++;
        if (ir_dec !== IDCODE) begin
            errors++; $display("FAIL reset_dec got %s want IDCODE", ir_dec.name());
        end
        checks++;
        if (tdo !== 1'b0 || tdo_en !== 1'b0) begin
            errors++; $display("FAIL reset_tdo got tdo=%b en=%b want 0/0", tdo, tdo_en);
        end
    endtask

    task automatic test_load_addr();
        logic [3:0] bits = 4'b0010;
        logic [3:0] want_tdo = 4'b0001;
        step(0, 0, 1);
        step(1, 0, 1); step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tap_state !== SHIFT_IR || tdo !== want_tdo[i] || tdo_en !== 1'b1) begin
                errors++;
                $display("FAIL addr_shift_tdo bit%0d got state=%s tdo=%b en=%b want SHIFT_IR/%b/1",
                         i, tap_state.name(), tdo, tdo_en, want_tdo[i]);
            end
            step(i == 3, bits[i], 1);
        end
        step(1, 0, 1);
        step(0, 0, 1);
        checks++;
        if (ir_dec !== ADDR_REGISTER || tap_state !== RUN_TEST_IDLE) begin
            errors++;
            $display("FAIL addr_load got %s/%s want ADDR_REGISTER/RUN_TEST_IDLE", ir_dec.name(), tap_state.name());
        end
    endtask

    task automatic test_tms_reset();
        tap_ctrl_fsm_t seq [5];
        seq = '{EXIT1_DR, UPDATE_DR, SELECT_DR, SELECT_IR, TEST_LOGIC_RESET};
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        checks++;
        if (tap_state !== SHIFT_DR || ir_dec !== ADDR_REGISTER) begin
            errors++;
            $display("FAIL tms5_enter got %s/%s want SHIFT_DR/ADDR_REGISTER", tap_state.name(), ir_dec.name());
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1);
            checks++;
            if (tap_state !== seq[i]) begin
                errors++; $display("FAIL tms5_seq%0d got %s want %s", i, tap_state.name(), seq[i].name());
            end
        end
        checks++;
        if (ir_dec !== IDCODE) begin
            errors++; $display("FAIL tms5_dec got %s want IDCODE", ir_dec.name());
        end
    endtask

    task automatic test_codes();
        goto_rti();
        load_ir(4'hA);
        checks++;
        if (ir_dec !== BYPASS) begin
            errors++; $display("FAIL code_A got %s want BYPASS", ir_dec.name());
        end
        load_ir(4'h3);
        checks++;
        if (ir_dec !== DATA_WR_REGISTER) begin
            errors++; $display("FAIL code_3 got %s want DATA_WR_REGISTER", ir_dec.name());
        end
        load_ir(4'hF);
        checks++;
        if (ir_dec !== BYPASS) begin
            errors++; $display("FAIL code_F got %s want BYPASS", ir_dec.name());
        end
    endtask

    task automatic test_mux();
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            tdo_dr = 1'(i % 2) ^ 1'($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (tdo !== tdo_dr || tdo_en !== 1'b1) begin
                errors++; $display("FAIL mux_shift_dr got tdo=%b en=%b want %b/1", tdo, tdo_en, tdo_dr);
            end
            step(0, 0, 1);
        end
        step(1, 0, 1); step(1, 0, 1); step(0, 0, 1);
        tdo_dr = 1'b1;
        #1;
        checks++;
        if (tap_state !== RUN_TEST_IDLE || tdo !== 1'b0 || tdo_en !== 1'b0) begin
            errors++;
            $display("FAIL mux_rti got %s tdo=%b en=%b want RUN_TEST_IDLE/0/0", tap_state.name(), tdo, tdo_en);
        end
        tdo_dr = 1'b0;
    endtask

    task automatic test_pause_resume();
        // DATA_RD code 4'h4: bits 0,0 then pause, then 1,0
        step(1, 0, 1); step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(0, 0, 1); step(1, 0, 1);
        step(0, 0, 1); step(0, 0, 1); step(1, 0, 1); step(0, 0, 1);
        checks++;
        if (tap_state !== SHIFT_IR || tdo !== 1'b0) begin
            errors++; $display("FAIL resume_state got %s tdo=%b want SHIFT_IR/0", tap_state.name(), tdo);
        end
        step(0, 1, 1); step(1, 0, 1);
        step(1, 0, 1); step(0, 0, 1);
        checks++;
        if (ir_dec !== DATA_RD_REGISTER) begin
            errors++; $display("FAIL resume_load got %s want DATA_RD_REGISTER", ir_dec.name());
        end
        // Capture then straight to update: captured 2'b01 becomes the instruction.
        step(1, 0, 1); step(1, 0, 1); step(0, 0, 1); step(1, 0, 1); step(1, 0, 1); step(0, 0, 1);
        checks++;
        if (ir_dec !== IDCODE || tap_state !== RUN_TEST_IDLE) begin
            errors++;
            $display("FAIL zero_shift got %s/%s want IDCODE/RUN_TEST_IDLE", ir_dec.name(), tap_state.name());
        end
    endtask

    task automatic test_mid_shift_reset();
        load_ir(4'h2);
        step(1, 0, 1); step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(0, 1, 1);
        step(0, 1, 0);
        checks++;
        if (tap_state !== TEST_LOGIC_RESET || ir_dec !== IDCODE) begin
            errors++;
            $display("FAIL midreset got %s/%s want TEST_LOGIC_RESET/IDCODE", tap_state.name(), ir_dec.name());
        end
        checks++;
        if (tdo !== 1'b0 || tdo_en !== 1'b0) begin
            errors++; $display("FAIL midreset_tdo got tdo=%b en=%b want 0/0", tdo, tdo_en);
        end
        step(0, 0, 1); step(0, 0, 1);
        checks++;
        if (ir_dec !== IDCODE) begin
            errors++; $display("FAIL midreset_noupdate got %s want IDCODE", ir_dec.name());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            tdo_dr = 1'($urandom);
            step(1'($urandom_range(0, 99) < 40), 1'($urandom), 1'($urandom_range(0, 199) != 0));
            checks++;
            if (tap_state !== m_state || ir_dec !== exp_dec() || tdo !== exp_tdo() || tdo_en !== exp_en()) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random cyc%0d got %s/%s tdo=%b en=%b want %s/%s tdo=%b en=%b",
                             i, tap_state.name(), ir_dec.name(), tdo, tdo_en,
                             m_state.name(), exp_dec().name(), exp_tdo(), exp_en());
                bad++;
            end
        end
    endtask

    initial begin
        tms = 1'b1; tdi = 1'b0; trstn = 1'b0; tdo_dr = 1'b0;
        build_tbl();
        #1;
        test_reset();
        test_load_addr();
        test_tms_reset();
        test_codes();
        test_mux();
        test_pause_resume();
        test_mid_shift_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
